sr_fetch_queue: RTL

//  Instruction fetch stage with a small prefetch queue. It sits directly upstream of
//  the decode stage. It generates sequential PCs and issues reads to a synchronous

---
 rtl/sr_fetch_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/sr_fetch_queue.sv
// Fetch stage: issues sequential word reads to a 1-cycle imem and buffers the
// returned {pc, instr} pairs in a small circular queue toward decode.
module sr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  input  logic        ready_i
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] q_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               inflight_q;
  logic [31:0]        inflight_pc_q, fetch_pc_q;
  logic               pop, push, issue;
  logic [CW:0]        occ;
  logic               unused_pc_lsbs;

  assign unused_pc_lsbs = ^redirect_pc_i[1:0];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o     = (count_q != '0);
  assign pc_o        = q_q[rd_ptr_q].pc;
  assign instr_o     = q_q[rd_ptr_q].instr;
  assign imem_addr_o = fetch_pc_q;

  assign pop  = valid_o & ready_i & ~redirect_i;
  assign push = inflight_q & ~redirect_i;

  // Occupancy after this cycle's pop, counting the in-flight read as a reserved slot.
  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue = ~rst & ~redirect_i & (occ < (CW+1)'(DEPTH));
  assign imem_req_o = issue;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      q_q           <= '0;
    end else if (redirect_i) begin
      // Flush wins over everything: the response arriving now is dropped.
      fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= fetch_pc_q;
        fetch_pc_q    <= fetch_pc_q + 32'd4;
      end
      if (push) begin
        q_q[wr_ptr_q] <= '{pc: inflight_pc_q, instr: imem_rdata_i};
        wr_ptr_q      <= next_ptr(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_d;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule
